// File: rtl/alarm_pkg.sv
// ============================================================================
// Module  : alarm_pkg
// Brief   : Encodings shared by the alarm main FSM and its keypad front end.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package alarm_pkg;

   localparam int DIGIT_W_DEFAULT = 2;

   typedef logic [1:0] key_status_t;

   localparam key_status_t KEY_OK    = 2'd0;
   localparam key_status_t KEY_OKNEG = 2'd1;
   localparam key_status_t KEY_ERROR = 2'd2;
   localparam key_status_t NO_KEY    = 2'd3;

   // Main alarm FSM states
   localparam logic [1:0] INACTIVO = 2'd0;
   localparam logic [1:0] ARMADO   = 2'd1;
   localparam logic [1:0] ESPERA   = 2'd2;
   localparam logic [1:0] ALARMA   = 2'd3;

endpackage

`default_nettype wire

// File: rtl/sync_edge_detect.sv
// ============================================================================
// Module  : sync_edge_detect
// Brief   : 2-flop synchroniser per bit plus a rising-edge pulse per bit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_edge_detect #(
   parameter int W = 1
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [W-1:0] async_i,
   output logic [W-1:0] sync_o,
   output logic [W-1:0] rise_o
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;
   logic [W-1:0] prev_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= '0;
         sync_q <= '0;
         prev_q <= '0;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign sync_o = sync_q;
   assign rise_o = sync_q & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/pin_entry_controller.sv
// ============================================================================
// Module  : pin_entry_controller
// Brief   : Keypad PIN collection, code check, inter-digit timeout, lockout.
//           Define PIN_PROG_EN to add PROG_REQ and in-field code programming.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pin_entry_controller
   import alarm_pkg::*;
#(
   parameter int                           PIN_LEN      = 4,
   parameter int                           DIGIT_W      = DIGIT_W_DEFAULT,
   parameter logic [PIN_LEN*DIGIT_W-1:0]   DEFAULT_CODE = 8'h1B,
   parameter int                           TIMEOUT_CYC  = 5000,
   parameter int                           MAX_FAILS    = 3,
   parameter int                           LOCKOUT_CYC  = 30000
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [DIGIT_W-1:0] KB_IN,
   input  logic               KB_RECV,
   input  logic               NEG_SEL,
`ifdef PIN_PROG_EN
   input  logic               PROG_REQ,
`endif
   output logic               KEY_VALID,
   output logic [1:0]         KEY_STATUS,
   output logic [2:0]         DIGIT_CNT,
   output logic               LOCKED
);

   localparam int CODE_W = PIN_LEN * DIGIT_W;
   localparam int TMR_MAX = (LOCKOUT_CYC > TIMEOUT_CYC) ? LOCKOUT_CYC : TIMEOUT_CYC;
   localparam int TMR_W  = $clog2(TMR_MAX);
   localparam int FAIL_W = $clog2(MAX_FAILS + 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_COLLECT = 3'd1;
   localparam logic [2:0] S_CHECK   = 3'd2;
   localparam logic [2:0] S_LOCKOUT = 3'd3;
   localparam logic [2:0] S_PROG    = 3'd4;

   logic [DIGIT_W:0]   sync_w;
   logic [DIGIT_W:0]   rise_w;
   logic               strobe_w;
   logic [DIGIT_W-1:0] digit_w;
   logic               unused_sync_w;

   // Strobe rides in the top bit so the digit sees exactly the same sync depth
   sync_edge_detect #(.W(DIGIT_W + 1)) u_kb_sync (
      .clk_i   (CLK),
      .rst_i   (RST),
      .async_i ({KB_RECV, KB_IN}),
      .sync_o  (sync_w),
      .rise_o  (rise_w)
   );

   assign strobe_w      = rise_w[DIGIT_W];
   assign digit_w       = sync_w[DIGIT_W-1:0];
   assign unused_sync_w = ^{rise_w[DIGIT_W-1:0], sync_w[DIGIT_W]};

   logic [2:0]        state_q,  state_d;
   logic [2:0]        cnt_q,    cnt_d;
   logic [CODE_W-1:0] entry_q,  entry_d;
   logic [TMR_W-1:0]  timer_q,  timer_d;
   logic [FAIL_W-1:0] fails_q,  fails_d;
   logic              valid_q,  valid_d;
   logic [1:0]        status_q, status_d;
   logic [CODE_W-1:0] code_w;
   logic [CODE_W-1:0] shifted_w;

   assign shifted_w = {entry_q[CODE_W-DIGIT_W-1:0], digit_w};

`ifdef PIN_PROG_EN
   logic [CODE_W-1:0] code_q, code_d;
   assign code_w = code_q;
`else
   assign code_w = DEFAULT_CODE;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      entry_d  = entry_q;
      timer_d  = timer_q;
      fails_d  = fails_q;
      valid_d  = 1'b0;
      status_d = status_q;
`ifdef PIN_PROG_EN
      code_d   = code_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (strobe_w) begin
               entry_d = {{(CODE_W-DIGIT_W){1'b0}}, digit_w};
               cnt_d   = 3'd1;
               timer_d = '0;
               state_d = S_COLLECT;
            end
         end
         S_COLLECT: begin
            if (strobe_w) begin
               entry_d = shifted_w;
               cnt_d   = cnt_q + 3'd1;
               timer_d = '0;
               if (cnt_d == 3'(PIN_LEN)) state_d = S_CHECK;
            end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
               cnt_d   = '0;
               timer_d = '0;
               state_d = S_IDLE;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         S_CHECK: begin
            valid_d = 1'b1;
            cnt_d   = '0;
            timer_d = '0;
            if (entry_q == code_w) begin
               status_d = NEG_SEL ? KEY_OKNEG : KEY_OK;
               fails_d  = '0;
               state_d  = S_IDLE;
`ifdef PIN_PROG_EN
               if (PROG_REQ) begin
                  status_d = KEY_OK;
                  state_d  = S_PROG;
               end
`endif
            end else begin
               status_d = KEY_ERROR;
               fails_d  = fails_q + FAIL_W'(1);
               state_d  = (fails_d == FAIL_W'(MAX_FAILS)) ? S_LOCKOUT : S_IDLE;
            end
         end
         S_LOCKOUT: begin
            if (timer_q == TMR_W'(LOCKOUT_CYC - 1)) begin
               timer_d = '0;
               fails_d = '0;
               state_d = S_IDLE;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
`ifdef PIN_PROG_EN
         S_PROG: begin
            if (strobe_w) begin
               entry_d = shifted_w;
               cnt_d   = cnt_q + 3'd1;
               timer_d = '0;
               if (cnt_d == 3'(PIN_LEN)) begin
                  code_d   = shifted_w;
                  valid_d  = 1'b1;
                  status_d = KEY_OK;
                  cnt_d    = '0;
                  state_d  = S_IDLE;
               end
            end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
               cnt_d   = '0;
               timer_d = '0;
               state_d = S_IDLE;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         entry_q  <= '0;
         timer_q  <= '0;
         fails_q  <= '0;
         valid_q  <= 1'b0;
         status_q <= NO_KEY;
`ifdef PIN_PROG_EN
         code_q   <= DEFAULT_CODE;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         entry_q  <= entry_d;
         timer_q  <= timer_d;
         fails_q  <= fails_d;
         valid_q  <= valid_d;
         status_q <= status_d;
`ifdef PIN_PROG_EN
         code_q   <= code_d;
`endif
      end
   end

   assign KEY_VALID  = valid_q;
   assign KEY_STATUS = status_q;
   assign DIGIT_CNT  = cnt_q;
   assign LOCKED     = (state_q == S_LOCKOUT);

endmodule

`default_nettype wire

// File: doc/pin_entry_controller.md
Name: pin_entry_controller

Overview:
- Sequences keypad digit entry for the alarm's main state machine.
- Synchronises the keypad strobe, collects PIN_LEN 2-bit digits and compares them against the stored code.
- Emits a one-cycle result pulse carrying an OK/OKNEG/ERROR status code.
- Enforces an inter-digit timeout and a lockout after repeated wrong codes, replacing direct key checking inside the main FSM.

Parameters:
- PIN_LEN, 4, digits per code (≥2)
- DIGIT_W, 2, bits per digit (keypad width)
- DEFAULT_CODE, 8'h1B, code after reset; first digit in MSBs (digits 0,1,2,3)
- TIMEOUT_CYC, 5000, max CLK cycles between digits
- MAX_FAILS, 3, consecutive wrong codes before lockout
- LOCKOUT_CYC, 30000, lockout duration in CLK cycles

Ports:
- CLK  in  1  system clock (low-speed oscillator)
- RST  in  1  synchronous, active-high reset
- KB_IN  in  DIGIT_W  keypad digit; stable ≥3 CLK around the KB_RECV rising edge
- KB_RECV  in  1  asynchronous keypad strobe; rising edge = digit present
- NEG_SEL  in  1  1: correct code reports KEY_OKNEG instead of KEY_OK
- KEY_VALID  out  1  one-cycle pulse, KEY_STATUS is new
- KEY_STATUS  out  2  OK=0, OKNEG=1, ERROR=2, NO_KEY=3; held between pulses
- DIGIT_CNT  out  3  digits captured in the current entry
- LOCKED  out  1  high during lockout

Behaviour:
- Reset values (RST sampled high on a CLK edge):
  - KEY_VALID=0, KEY_STATUS=NO_KEY, DIGIT_CNT=0, LOCKED=0.
  - State=IDLE, fail counter=0, timers=0, code register=DEFAULT_CODE.
  - Reset mid-entry discards captured digits.
- Strobe and digit synchronisation:
  - KB_RECV passes through a 2-flop synchroniser followed by a rising-edge detect. This gives a 3-cycle strobe latency.
  - KB_IN is synchronised through the same 2-flop depth and sampled on the detected edge.
- FSM states: IDLE, COLLECT, CHECK, LOCKOUT.
  - IDLE: on a strobe edge, store the digit at index 0, set DIGIT_CNT=1, clear the inter-digit timer, go to COLLECT.
  - COLLECT, on a strobe edge: shift the digit into the entry register (MSB-first) and increment DIGIT_CNT.
    - When DIGIT_CNT reaches PIN_LEN, go to CHECK.
  - COLLECT, timer reaches TIMEOUT_CYC-1 with no strobe: discard the entry, DIGIT_CNT=0, go to IDLE. No result is issued and the fail count is unchanged.
  - CHECK lasts exactly 1 cycle and drives KEY_VALID=1.
    - Match: KEY_STATUS = NEG_SEL ? OKNEG : OK (NEG_SEL sampled in CHECK); fail counter cleared.
    - Mismatch: KEY_STATUS=ERROR; fail counter incremented.
    - Next state: if the incremented fail count equals MAX_FAILS, go to LOCKOUT; otherwise go to IDLE. DIGIT_CNT=0.
  - LOCKOUT: LOCKED=1 and all strobes are ignored.
    - After LOCKOUT_CYC cycles: fail counter=0, LOCKED=0, go to IDLE.
    - A strobe arriving on the final lockout cycle is ignored.
- Latency: the result pulse comes 1 cycle after the final digit's detected edge, i.e. 4 CLK after the raw KB_RECV rise.
- Simultaneous events:
  - Strobe edge and timeout in the same COLLECT cycle: the strobe wins; the digit is accepted and the timer is cleared.
  - Strobe edge during CHECK: dropped.
- Width rules: timers and counters are $clog2-sized for their parameters; comparison is on the full PIN_LEN*DIGIT_W code.

Optional Feature:
- Macro: PIN_PROG_EN.
- When defined:
  - Extra input PROG_REQ and extra state PROG.
  - A matching CHECK with PROG_REQ=1 reports OK and enters PROG instead of IDLE.
  - PROG collects PIN_LEN digits with the same timeout rules, loads them into the code register, and pulses KEY_VALID with KEY_STATUS=OK.
  - A timeout in PROG leaves the code unchanged, issues no result, and returns to IDLE.
- When undefined: no PROG_REQ port, no PROG state; the code register is the constant DEFAULT_CODE.

Decomposition:
- Shared package alarm_pkg holds:
  - the KEY_OK/KEY_OKNEG/KEY_ERROR/NO_KEY encodings (shared with the main FSM);
  - the DIGIT_W default;
  - the INACTIVO/ARMADO/ESPERA/ALARMA state encodings.
- One sub-module, sync_edge_detect: 2-flop synchroniser plus rising-edge pulse. It is reused for any other asynchronous input (sensors, CTRL_RECV).

Test Plan:
- Reset, then strobe digits 0,1,2,3 with NEG_SEL=0 -> KEY_VALID pulse 4 CLK after the 4th KB_RECV rise, KEY_STATUS=0, DIGIT_CNT returns to 0.
- Same sequence with NEG_SEL=1 -> KEY_STATUS=1; sequence 0,1,2,2 -> KEY_STATUS=2.
- Three wrong codes in a row -> third pulse shows ERROR and LOCKED=1 for 30000 cycles; strobes during lockout produce no DIGIT_CNT change; correct code after lockout -> OK.
- Two digits, then idle 5000 cycles -> DIGIT_CNT=0, no KEY_VALID; a following full correct code -> OK.
- Assert RST after 3 digits -> DIGIT_CNT=0, KEY_STATUS=3; the next 4 correct digits give OK.
- With PIN_PROG_EN: correct code with PROG_REQ=1, then 3,3,2,2 -> OK; old code now gives ERROR; 3,3,2,2 gives OK.
